// File: rtl/button_gesture_if.sv
// Button gesture interface: the raw pin plus every decoded output.
//   slave  : decoder side (samples button, drives the decoded signals)
//   master : consumer side (drives button, observes the decoded signals)
// Signals:
//   button        raw asynchronous push-button pin
//   level         debounced pressed state (1 = pressed)
//   r_edge/f_edge 1-cycle pulses on debounced press / release
//   short_press, long_press, double_press  1-cycle gesture pulses
//   hold          high from long_press until release
interface button_gesture_if;
    logic button;
    logic level;
    logic r_edge;
    logic f_edge;
    logic short_press;
    logic long_press;
    logic double_press;
    logic hold;

    modport slave (
        input  button,
        output level, r_edge, f_edge, short_press, long_press, double_press, hold
    );

    modport master (
        output button,
        input  level, r_edge, f_edge, short_press, long_press, double_press, hold
    );
endinterface

// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: synchronises and debounces the raw button pin, then
// classifies each gesture as short, long or double press (one-clock pulses).
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   btn  button_gesture_if.slave (button in; level, r_edge, f_edge,
//        short_press, long_press, double_press, hold out)
module button_gesture_decoder #(
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 25_000_000,
    parameter int DCLICK_CYC   = 15_000_000
) (
    input  logic             clk,
    input  logic             rst,
    button_gesture_if.slave  btn
);
    localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TMAX = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0] DC_LAST   = TW'(DCLICK_CYC - 1);
    localparam logic [TW-1:0] T_SAT     = {TW{1'b1}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_LONG   = 3'd2;
    localparam logic [2:0] S_WAIT2  = 3'd3;
    localparam logic [2:0] S_PRESS2 = 3'd4;

    logic          sync0, sync1, level_q;
    logic [DW-1:0] db_cnt;
    logic          r_q, f_q;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic          short_q, long_q, dbl_q, hold_q;

    // Pin mapped into the "1 = pressed" domain before synchronising.
    logic pin_p;
    assign pin_p = (ACTIVE_LOW != 0) ? ~btn.button : btn.button;

    logic differ, db_hit;
    assign differ = sync1 ^ level_q;
    assign db_hit = differ && (db_cnt == DB_LAST);

    // Synchroniser + debounce. Edge pulses are registered on the same edge
    // that flips level, so they line up with the first cycle of the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            level_q <= 1'b0;
            db_cnt  <= '0;
            r_q     <= 1'b0;
            f_q     <= 1'b0;
        end else begin
            sync0 <= pin_p;
            sync1 <= sync0;
            r_q   <= 1'b0;
            f_q   <= 1'b0;
            if (!differ) begin
                db_cnt <= '0;
            end else if (db_hit) begin
                db_cnt  <= '0;
                level_q <= ~level_q;
                r_q     <= ~level_q;
                f_q     <= level_q;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Gesture FSM, driven only by the debounced edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            if (timer != T_SAT) timer <= timer + TW'(1);
            case (state)
                S_IDLE: begin
                    if (r_q) begin
                        state <= S_PRESS1;
                        timer <= '0;
                    end
                end
                S_PRESS1: begin
                    // A release landing on the long threshold counts as a
                    // short press: the button is no longer held.
                    if (f_q) begin
                        state <= S_WAIT2;
                        timer <= '0;
                    end else if (timer == LONG_LAST) begin
                        long_q <= 1'b1;
                        hold_q <= 1'b1;
                        state  <= S_LONG;
                        timer  <= '0;
                    end
                end
                S_LONG: begin
                    if (f_q) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end
                end
                S_WAIT2: begin
                    if (timer >= DC_LAST) begin
                        short_q <= 1'b1;
                        state   <= S_IDLE;
                        timer   <= '0;
                    end else if (r_q) begin
                        state <= S_PRESS2;
                        timer <= '0;
                    end
                end
                S_PRESS2: begin
                    if (f_q) begin
                        dbl_q <= 1'b1;
                        state <= S_IDLE;
                        timer <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
            // hold falls on the same edge that raises f_edge.
            if (db_hit && level_q) hold_q <= 1'b0;
        end
    end

    assign btn.level        = level_q;
    assign btn.r_edge       = r_q;
    assign btn.f_edge       = f_q;
    assign btn.short_press  = short_q;
    assign btn.long_press   = long_q;
    assign btn.double_press = dbl_q;
    assign btn.hold         = hold_q;
endmodule

// File: tb/tb_button_gesture_decoder.sv
// Testbench for button_gesture_decoder. Pulse expectations (kind + cycle) are
// queued when the pin is driven and popped as the DUT emits pulses.
module tb_button_gesture_decoder;
    localparam int D  = 4;
    localparam int L  = 20;
    localparam int DC = 10;
    // Raw change -> level/edge pulse latency.
    localparam int LAT = 2 + D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    button_gesture_if bus();

    button_gesture_decoder #(
        .ACTIVE_LOW  (1),
        .DEBOUNCE_CYC(D),
        .LONG_CYC    (L),
        .DCLICK_CYC  (DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t   sb[$];
    string kname [5] = '{"r_edge", "f_edge", "short_press", "long_press", "double_press"};
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic int outs();
        return int'({bus.level, bus.r_edge, bus.f_edge, bus.short_press,
                     bus.long_press, bus.double_press, bus.hold});
    endfunction

    logic [4:0] pulses;
    assign pulses = {bus.double_press, bus.long_press, bus.short_press, bus.f_edge, bus.r_edge};

    // Scoreboard consumer: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        ev_t e;
        for (int k = 0; k < 5; k++) begin
            if (pulses[k]) begin
                if (sb.size() == 0) begin
                    chk({kname[k], "_unexpected_at_cycle"}, cyc, -1);
                end else begin
                    e = sb.pop_front();
                    chk({kname[k], "_kind"}, k, e.kind);
                    chk({kname[k], "_cycle"}, cyc, e.at);
                end
            end
        end
        if ($countones(pulses[4:2]) > 1)
            chk("one_gesture_per_cycle", $countones(pulses[4:2]), 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, m;
        bus.button = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Long press: 30 clk low. PRESS1 entered 1 clk after r_edge, long
        // declared when the timer shows L-1, pulse one clock later.
        t0 = cyc;
        bus.button = 1'b0;
        push(0, t0 + LAT);
        push(3, t0 + LAT + L + 1);
        wait_cyc(t0 + LAT);
        chk("long_level_high", int'(bus.level), 1);
        wait_cyc(t0 + LAT + L + 1);
        chk("hold_at_long_press", int'(bus.hold), 1);
        wait_cyc(t0 + 30);
        bus.button = 1'b1;
        t1 = cyc;
        push(1, t1 + LAT);
        wait_cyc(t1 + LAT - 1);
        chk("hold_before_release", int'(bus.hold), 1);
        wait_cyc(t1 + LAT);
        chk("hold_drops_with_f_edge", int'(bus.hold), 0);
        chk("long_level_low", int'(bus.level), 0);
        wait_cyc(t1 + 40);

        // Short press: 8 clk low. WAIT2 entered 1 clk after f_edge, timeout
        // cycle at timer DC-1, short_press one clock after that.
        t0 = cyc;
        bus.button = 1'b0;
        push(0, t0 + LAT);
        wait_cyc(t0 + 8);
        bus.button = 1'b1;
        t1 = cyc;
        push(1, t1 + LAT);
        push(2, t1 + LAT + DC + 1);
        wait_cyc(t1 + 40);

        // Double press: 8 low, 5 high, 8 low.
        t0 = cyc;
        bus.button = 1'b0;
        push(0, t0 + LAT);
        wait_cyc(t0 + 8);
        bus.button = 1'b1;
        push(1, t0 + 8 + LAT);
        wait_cyc(t0 + 13);
        bus.button = 1'b0;
        push(0, t0 + 13 + LAT);
        wait_cyc(t0 + 21);
        bus.button = 1'b1;
        push(1, t0 + 21 + LAT);
        push(4, t0 + 21 + LAT + 1);
        wait_cyc(t0 + 60);

        // Glitches shorter than the debounce window.
        repeat (10) begin
            bus.button = 1'b0;
            repeat (3) @(negedge clk);
            bus.button = 1'b1;
            repeat (5) @(negedge clk);
            chk("glitch_level", int'(bus.level), 0);
        end
        repeat (10) @(negedge clk);

        // Button held through reset: counts as a fresh press after release.
        rst = 1'b1;
        bus.button = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pin_low_outputs", outs(), 0);
        rst = 1'b0;
        t0 = cyc;
        push(0, t0 + LAT);
        push(3, t0 + LAT + L + 1);
        wait_cyc(t0 + LAT + L + 1);
        chk("held_reset_hold", int'(bus.hold), 1);
        bus.button = 1'b1;
        t1 = cyc;
        push(1, t1 + LAT);
        wait_cyc(t1 + 40);

        // Reset during WAIT2 discards the pending short press.
        t0 = cyc;
        bus.button = 1'b0;
        push(0, t0 + LAT);
        wait_cyc(t0 + 8);
        bus.button = 1'b1;
        t1 = cyc;
        push(1, t1 + LAT);
        wait_cyc(t1 + LAT + 4);
        rst = 1'b1;
        m = cyc;
        wait_cyc(m + 1);
        chk("reset_in_wait2_outputs", outs(), 0);
        rst = 1'b0;
        wait_cyc(m + 40);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
